// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI mode-0 slave that bursts words into or out of banked word memories.
module spi_mem_bridge #(
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS = 2,
  parameter int RD_LATENCY = 1,
  localparam int BANK_BITS = NUM_BANKS > 2 ? $clog2(NUM_BANKS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            spi_SCLK,
  input  logic                            spi_SSEL,
  input  logic                            spi_MOSI,
  output logic                            spi_MISO,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [BANK_BITS-1:0]            rd_bank,
  input  logic [NUM_BANKS*WORD_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [WORD_WIDTH-1:0]           wr_data,
  output logic [NUM_BANKS-1:0]            wr_enable,
  output logic                            busy,
  output logic                            bad_bank
);
  localparam int HDR = 1 + BANK_BITS + ADDR_WIDTH;
  localparam int RW = WORD_WIDTH > HDR ? WORD_WIDTH : HDR;
  localparam int CW = $clog2(RW);
  typedef enum logic [2:0] {IDLE, HEADER, WRITE, READ, DRAIN} state_t;
  state_t state, state_n;
  logic [2:0] sclk_q, ssel_q;
  logic [1:0] mosi_q;
  logic [CW-1:0] cnt;
  logic [RW-2:0] rx;
  logic [BANK_BITS-1:0] bank;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [RD_LATENCY:0] pend;
  logic [WORD_WIDTH-1:0] hold, tx;
  logic sclk_rise, sclk_fall, ssel_rise, ssel_fall, mosi, done, hdr_done, wr_go, rd_go, issue, h_bad;
  logic [HDR-1:0] hdr;
  logic [WORD_WIDTH-1:0] word;
  logic [BANK_BITS-1:0] h_bank;
  logic [ADDR_WIDTH-1:0] h_addr;
  // q[1] is the synchronized level, q[2] its previous value for edge detection
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ssel_rise = ssel_q[1] & ~ssel_q[2];
  assign ssel_fall = ~ssel_q[1] & ssel_q[2];
  assign mosi = mosi_q[1];
  assign hdr = {rx[HDR-2:0], mosi};
  assign word = {rx[WORD_WIDTH-2:0], mosi};
  assign h_bank = hdr[ADDR_WIDTH +: BANK_BITS];
  assign h_addr = hdr[ADDR_WIDTH-1:0];
  assign h_bad = {1'b0, h_bank} >= (BANK_BITS+1)'(NUM_BANKS);
  assign done = sclk_rise && cnt == CW'(state == HEADER ? HDR - 1 : WORD_WIDTH - 1);
  assign hdr_done = state == HEADER && done;
  assign wr_go = state == WRITE && done;
  assign rd_go = state == READ && done;
  assign issue = (hdr_done && !h_bad && !hdr[HDR-1]) || rd_go;
  assign busy = state != IDLE;
  always_comb begin
    state_n = ssel_rise ? IDLE :
              state == IDLE && ssel_fall ? HEADER :
              hdr_done ? (h_bad ? DRAIN : hdr[HDR-1] ? WRITE : READ) : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sclk_q <= '0;
      ssel_q <= '0;
      mosi_q <= '0;
      state <= IDLE;
      cnt <= '0;
      rx <= '0;
      bank <= '0;
      wptr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_enable <= '0;
      bad_bank <= 1'b0;
      rd_addr <= '0;
      rd_bank <= '0;
      pend <= '0;
      hold <= '0;
      tx <= '0;
      spi_MISO <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_SCLK};
      ssel_q <= {ssel_q[1:0], spi_SSEL};
      mosi_q <= {mosi_q[0], spi_MOSI};
      state <= state_n;
      cnt <= state == IDLE || done ? '0 : cnt + CW'(sclk_rise);
      if (sclk_rise) rx <= {rx[RW-3:0], mosi};
      wr_enable <= wr_go ? NUM_BANKS'(1) << bank : '0;
      bad_bank <= hdr_done && h_bad;
      if (hdr_done) begin
        bank <= h_bank;
        wptr <= h_addr;
      end
      if (wr_go) begin
        wr_addr <= wptr;
        wr_data <= word;
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      // prefetch one word ahead: the header fetches slot 1's word, each slot boundary the next
      if (issue) begin
        rd_addr <= state == HEADER ? h_addr : rd_addr + ADDR_WIDTH'(1);
        rd_bank <= state == HEADER ? h_bank : rd_bank;
      end
      pend <= {pend[RD_LATENCY-1:0], issue};
      if (pend[RD_LATENCY]) hold <= rd_data[int'(rd_bank) * WORD_WIDTH +: WORD_WIDTH];
      tx <= hdr_done ? '0 : rd_go ? hold : state == READ && sclk_fall ? tx << 1 : tx;
      spi_MISO <= state == READ && (sclk_fall ? tx[WORD_WIDTH-1] : spi_MISO);
    end
endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: directed SPI frames against default, 3-bank and 4-cycle-latency bridges.
module tb_spi_mem_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, sclk, ssel, mosi;
  logic miso0, busy0, bad0, miso3, busy3, bad3, miso4, busy4, bad4;
  logic [9:0] rd_addr0, wr_addr0, rd_addr3, wr_addr3, rd_addr4, wr_addr4;
  logic [0:0] rd_bank0, rd_bank4;
  logic [1:0] rd_bank3;
  logic [71:0] rd_data0, rd_data4;
  logic [107:0] rd_data3;
  logic [35:0] wr_data0, wr_data3, wr_data4;
  logic [1:0] wr_enable0, wr_enable4;
  logic [2:0] wr_enable3;
  logic [35:0] m0 [1024];
  logic [9:0] a1, a2, a3;
  logic [127:0] rx0, rx3, rx4;
  logic [9:0] wa [64];
  logic [35:0] wd [64];
  logic [1:0] we [64];
  int wcnt0 = 0, wcnt3 = 0, bcnt3 = 0;
  int cmp = 0, nfail = 0;

  spi_mem_bridge u0 (.clk(clk), .reset(reset), .spi_SCLK(sclk), .spi_SSEL(ssel), .spi_MOSI(mosi), .spi_MISO(miso0),
    .rd_addr(rd_addr0), .rd_bank(rd_bank0), .rd_data(rd_data0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .wr_enable(wr_enable0), .busy(busy0), .bad_bank(bad0));
  spi_mem_bridge #(.NUM_BANKS(3)) u3 (.clk(clk), .reset(reset), .spi_SCLK(sclk), .spi_SSEL(ssel), .spi_MOSI(mosi),
    .spi_MISO(miso3), .rd_addr(rd_addr3), .rd_bank(rd_bank3), .rd_data(rd_data3), .wr_addr(wr_addr3),
    .wr_data(wr_data3), .wr_enable(wr_enable3), .busy(busy3), .bad_bank(bad3));
  spi_mem_bridge #(.RD_LATENCY(4)) u4 (.clk(clk), .reset(reset), .spi_SCLK(sclk), .spi_SSEL(ssel), .spi_MOSI(mosi),
    .spi_MISO(miso4), .rd_addr(rd_addr4), .rd_bank(rd_bank4), .rd_data(rd_data4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .wr_enable(wr_enable4), .busy(busy4), .bad_bank(bad4));

  assign rd_data3 = '0;
  initial begin
    for (int i = 0; i < 1024; i++) m0[i] = '0;
    m0[10'h3FF] = 36'h0000000AA;
    m0[10'h000] = 36'h0000000BB;
  end
  // bank 1 reads back all ones so a wrong bank select is visible
  always @(posedge clk) begin
    rd_data0 <= {36'hFFFFFFFFF, m0[rd_addr0]};
    a1 <= rd_addr4;
    a2 <= a1;
    a3 <= a2;
    rd_data4 <= {36'hFFFFFFFFF, m0[a3]};
  end
  always @(negedge clk) begin
    if (|wr_enable0) begin
      wa[wcnt0 & 63] <= wr_addr0;
      wd[wcnt0 & 63] <= wr_data0;
      we[wcnt0 & 63] <= wr_enable0;
      wcnt0 <= wcnt0 + 1;
    end
    if (|wr_enable3) wcnt3 <= wcnt3 + 1;
    if (bad3) bcnt3 <= bcnt3 + 1;
  end

  task automatic half();
    repeat (4) @(negedge clk);
  endtask
  task automatic xfer(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      half();
      sclk = 1'b1;
      rx0 = {rx0[126:0], miso0};
      rx3 = {rx3[126:0], miso3};
      rx4 = {rx4[126:0], miso4};
      half();
      sclk = 1'b0;
    end
  endtask
  task automatic frame_begin();
    ssel = 1'b0;
    half();
  endtask
  task automatic frame_end();
    half();
    ssel = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ssel = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    cmp++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL reset_busy got %h want 0", busy0); end
    cmp++; if (miso0 !== 1'b0) begin nfail++; $display("FAIL reset_miso got %h want 0", miso0); end
    cmp++; if (wr_enable0 !== 2'b00) begin nfail++; $display("FAIL reset_wr_enable got %h want 0", wr_enable0); end
    cmp++; if (bad0 !== 1'b0) begin nfail++; $display("FAIL reset_bad_bank got %h want 0", bad0); end
    cmp++; if (rd_addr0 !== 10'h0 || rd_bank0 !== 1'b0) begin nfail++; $display("FAIL reset_rd got %h/%h want 0/0", rd_addr0, rd_bank0); end
    cmp++; if (wr_addr0 !== 10'h0) begin nfail++; $display("FAIL reset_wr_addr got %h want 0", wr_addr0); end
    cmp++; if (wr_data0 !== 36'h0) begin nfail++; $display("FAIL reset_wr_data got %h want 0", wr_data0); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_write_burst();
    int b = wcnt0;
    frame_begin();
    xfer(128'hFFE, 12);
    cmp++; if (busy0 !== 1'b1) begin nfail++; $display("FAIL wb_busy_mid got %h want 1", busy0); end
    xfer({36'h123456789, 36'hABCDEF012}, 72);
    frame_end();
    cmp++; if (wcnt0 - b !== 2) begin nfail++; $display("FAIL wb_count got %0d want 2", wcnt0 - b); end
    cmp++; if (we[b] !== 2'b10 || wa[b] !== 10'h3FE) begin nfail++; $display("FAIL wb_w0_en_addr got %h/%h want 2/3fe", we[b], wa[b]); end
    cmp++; if (wd[b] !== 36'h123456789) begin nfail++; $display("FAIL wb_w0_data got %h want 123456789", wd[b]); end
    cmp++; if (we[b+1] !== 2'b10 || wa[b+1] !== 10'h3FF) begin nfail++; $display("FAIL wb_w1_en_addr got %h/%h want 2/3ff", we[b+1], wa[b+1]); end
    cmp++; if (wd[b+1] !== 36'hABCDEF012) begin nfail++; $display("FAIL wb_w1_data got %h want abcdef012", wd[b+1]); end
    cmp++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL wb_busy_after got %h want 0", busy0); end
  endtask

  task automatic read_frame();
    frame_begin();
    xfer(128'h3FF, 12);
    xfer(128'h0, 108);
    frame_end();
  endtask

  task automatic test_read_wrap();
    int b = wcnt0;
    read_frame();
    cmp++; if (rx0[107:72] !== 36'h0) begin nfail++; $display("FAIL rd_slot0 got %h want 0", rx0[107:72]); end
    cmp++; if (rx0[71:36] !== 36'h0000000AA) begin nfail++; $display("FAIL rd_slot1 got %h want 0000000aa", rx0[71:36]); end
    cmp++; if (rx0[35:0] !== 36'h0000000BB) begin nfail++; $display("FAIL rd_slot2 got %h want 0000000bb", rx0[35:0]); end
    cmp++; if (wcnt0 !== b) begin nfail++; $display("FAIL rd_no_write got %0d want %0d", wcnt0, b); end
  endtask

  task automatic test_latency();
    read_frame();
    cmp++; if (rx4[107:72] !== 36'h0) begin nfail++; $display("FAIL lat4_slot0 got %h want 0", rx4[107:72]); end
    cmp++; if (rx4[71:36] !== 36'h0000000AA) begin nfail++; $display("FAIL lat4_slot1 got %h want 0000000aa", rx4[71:36]); end
    cmp++; if (rx4[35:0] !== 36'h0000000BB) begin nfail++; $display("FAIL lat4_slot2 got %h want 0000000bb", rx4[35:0]); end
  endtask

  task automatic test_bad_bank();
    int b = wcnt3;
    int bb = bcnt3;
    frame_begin();
    xfer(128'h0C00, 13);
    repeat (4) @(negedge clk);
    cmp++; if (busy3 !== 1'b1) begin nfail++; $display("FAIL bad_busy_mid got %h want 1", busy3); end
    xfer(128'h0, 72);
    frame_end();
    cmp++; if (bcnt3 - bb !== 1) begin nfail++; $display("FAIL bad_pulses got %0d want 1", bcnt3 - bb); end
    cmp++; if (wcnt3 !== b) begin nfail++; $display("FAIL bad_no_write got %0d want %0d", wcnt3, b); end
    cmp++; if (rx3[71:0] !== 72'h0) begin nfail++; $display("FAIL bad_miso got %h want 0", rx3[71:0]); end
    cmp++; if (busy3 !== 1'b0) begin nfail++; $display("FAIL bad_busy_after got %h want 0", busy3); end
  endtask

  task automatic test_partial();
    int b = wcnt0;
    frame_begin();
    xfer({12'h810, 36'hFEDCBA987, 20'hABCDE}, 68);
    frame_end();
    cmp++; if (wcnt0 - b !== 1) begin nfail++; $display("FAIL part_count got %0d want 1", wcnt0 - b); end
    cmp++; if (we[b] !== 2'b01 || wa[b] !== 10'h010) begin nfail++; $display("FAIL part_en_addr got %h/%h want 1/010", we[b], wa[b]); end
    cmp++; if (wd[b] !== 36'hFEDCBA987) begin nfail++; $display("FAIL part_data got %h want fedcba987", wd[b]); end
  endtask

  task automatic test_reset_mid();
    int b = wcnt0;
    frame_begin();
    xfer({12'h855, 5'b10110}, 17);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    xfer(128'h7FFFFFFF, 31);
    repeat (8) @(negedge clk);
    cmp++; if (wcnt0 !== b) begin nfail++; $display("FAIL rst_no_write got %0d want %0d", wcnt0, b); end
    cmp++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL rst_busy got %h want 0", busy0); end
    ssel = 1'b1;
    repeat (8) @(negedge clk);
    frame_begin();
    xfer({12'hC20, 36'h0F0F0F0F0}, 48);
    frame_end();
    cmp++; if (wcnt0 - b !== 1) begin nfail++; $display("FAIL rst_new_count got %0d want 1", wcnt0 - b); end
    cmp++; if (we[b] !== 2'b10 || wa[b] !== 10'h020) begin nfail++; $display("FAIL rst_new_en_addr got %h/%h want 2/020", we[b], wa[b]); end
    cmp++; if (wd[b] !== 36'h0F0F0F0F0) begin nfail++; $display("FAIL rst_new_data got %h want 0f0f0f0f0", wd[b]); end
  endtask

  initial begin
    rx0 = '0; rx3 = '0; rx4 = '0;
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_latency();
    test_bad_bank();
    test_partial();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, nfail);
    $finish;
  end
endmodule
